scroll_frame: RTL and testbench

Upstream frame source for the 5x7 LED matrix scanner. Holds a message of up to DEPTH 5-bit columns written by the control logic, and presents a 7-column window of it as the 35-bit `ens` frame. The window auto-scrolls one column per prescaler period, wrapping around the message. Output feeds the scanner's `ens` input directly.

---
 rtl/scroll_frame.sv | 157 +++++++++++++++
 tb/tb_scroll_frame.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_frame.sv
// scroll_frame: message store and auto-scrolling 7-column window for the 5x7 LED scanner.
// The control logic appends 5-bit columns. The module presents a 7-column window
// of the message as the 35-bit ens frame, and the window wraps around the message.
// Optional feature: define SCROLL_DIR_EN to add the dir input (1 = scroll right).
module scroll_frame #(
    parameter int DEPTH     = 32,
    parameter int STEP_LOG2 = 22
) (
    input  logic                       CLOCK_50,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [4:0]                 wr_data,
    input  logic                       clr,
    input  logic                       pause,
`ifdef SCROLL_DIR_EN
    input  logic                       dir,
`endif
    output logic [34:0]                ens,
    output logic [$clog2(DEPTH+1)-1:0] col_count,
    output logic                       full,
    output logic                       overflow,
    output logic                       frame_step
);
    localparam int CW = $clog2(DEPTH+1);   // length / start width
    localparam int AW = $clog2(DEPTH);     // buffer address width
    localparam int PW = $clog2(DEPTH+8);   // holds start+c before reduction

    typedef enum logic [1:0] {S_EMPTY, S_RUN, S_HOLD} state_t;

    state_t               state, state_nxt;
    logic [4:0]           col_buf [DEPTH];
    logic [CW-1:0]        len;
    logic [CW-1:0]        start;
    logic [CW-1:0]        start_nxt;
    logic [STEP_LOG2-1:0] presc;
    logic                 step_pend;
    logic                 run;
    logic                 wr_ok;
    logic                 wr_drop;
    logic                 advance;
    logic [34:0]          win;

    // Message index of window column c. start < len and c <= 6, so start+c < len+6.
    // Seven conditional subtractions cover the worst case of len = 1.
    function automatic logic [PW-1:0] wrap_idx(input logic [CW-1:0] s,
                                               input logic [CW-1:0] l,
                                               input int            c);
        logic [PW-1:0] idx;
        idx = PW'(s) + PW'(c);
        for (int k = 0; k < 7; k++) begin
            if (idx >= PW'(l))
                idx = idx - PW'(l);
        end
        return idx;
    endfunction

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)
            state <= S_EMPTY;
        else
            state <= state_nxt;
    end

    // FSM next state: clr always returns to EMPTY, and pause selects RUN or HOLD
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (wr_ok)  state_nxt = pause ? S_HOLD : S_RUN;
                S_RUN:   if (pause)  state_nxt = S_HOLD;
                S_HOLD:  if (!pause) state_nxt = S_RUN;
                default:             state_nxt = S_EMPTY;
            endcase
        end
    end

    // FSM outputs and write/advance qualifiers; clr overrides any write or advance
    always_comb begin
        run       = (state == S_RUN);
        full      = (len == CW'(DEPTH));
        col_count = len;
        wr_ok     = wr_en & ~full & ~clr;
        wr_drop   = wr_en &  full & ~clr;
        advance   = run & ~clr & (&presc);
    end

    // Next window start, computed from the pre-write length
    always_comb begin
        start_nxt = start + CW'(1);
        if (start_nxt == len)
            start_nxt = '0;
`ifdef SCROLL_DIR_EN
        if (dir)
            start_nxt = (start == '0) ? len - CW'(1) : start - CW'(1);
`endif
    end

    // Control state: length, window start, prescaler, sticky overflow, pending step flag
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            start     <= '0;
            presc     <= '0;
            overflow  <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_pend <= advance;
            if (clr) begin
                len      <= '0;
                start    <= '0;
                presc    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_ok)
                    len <= len + CW'(1);
                if (wr_drop)
                    overflow <= 1'b1;
                if (run)
                    presc <= presc + STEP_LOG2'(1);
                if (advance)
                    start <= start_nxt;
            end
        end
    end

    // Column storage; slot len is free whenever a write is accepted
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok)
            col_buf[len[AW-1:0]] <= wr_data;
    end

    // Window assembly: bit r*7+c is row r of message column (start+c) mod len
    always_comb begin
        win = '0;
        if (len != '0) begin
            for (int c = 0; c < 7; c++) begin
                for (int r = 0; r < 5; r++)
                    win[r*7+c] = col_buf[AW'(wrap_idx(start, len, c))][r];
            end
        end
    end

    // Registered frame; frame_step marks the first cycle that shows an advanced window
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ens        <= '0;
            frame_step <= 1'b0;
        end else begin
            ens        <= win;
            frame_step <= step_pend;
        end
    end

endmodule

// File: tb/tb_scroll_frame.sv
// tb_scroll_frame: directed table-driven bench for scroll_frame (DEPTH = 8, STEP_LOG2 = 2).
module tb_scroll_frame;
    localparam int DEPTH     = 8;
    localparam int STEP_LOG2 = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [4:0]  wr_data = '0;
    logic        clr     = 1'b0;
    logic        pause   = 1'b0;
`ifdef SCROLL_DIR_EN
    logic        dir     = 1'b0;
`endif
    logic [34:0] ens;
    logic [3:0]  col_count;
    logic        full;
    logic        overflow;
    logic        frame_step;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scroll_frame #(.DEPTH(DEPTH), .STEP_LOG2(STEP_LOG2)) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr        (clr),
        .pause      (pause),
`ifdef SCROLL_DIR_EN
        .dir        (dir),
`endif
        .ens        (ens),
        .col_count  (col_count),
        .full       (full),
        .overflow   (overflow),
        .frame_step (frame_step)
    );

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_data;
        logic       clr;
        logic       pause;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic w, input logic [4:0] d, input logic c,
                                input logic p, input logic [3:0] n, input logic f,
                                input logic o);
        vec_t v;
        v.wr_en = w; v.wr_data = d; v.clr = c; v.pause = p;
        v.exp_count = n; v.exp_full = f; v.exp_ovf = o;
        return v;
    endfunction

    // Transpose seven 5-bit columns into the ens layout (bit r*7+c).
    function automatic logic [34:0] frame_of(input logic [4:0] c0, input logic [4:0] c1,
                                             input logic [4:0] c2, input logic [4:0] c3,
                                             input logic [4:0] c4, input logic [4:0] c5,
                                             input logic [4:0] c6);
        logic [4:0]  cols [7];
        logic [34:0] f;
        cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
        cols[4] = c4; cols[5] = c5; cols[6] = c6;
        f = '0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 5; r++)
                f[r*7+c] = cols[c][r];
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            clr     = vecs[i].clr;
            pause   = vecs[i].pause;
            tick();
            chk($sformatf("v%0d_col_count", i), 64'(col_count), 64'(vecs[i].exp_count));
            chk($sformatf("v%0d_full", i),      64'(full),      64'(vecs[i].exp_full));
            chk($sformatf("v%0d_overflow", i),  64'(overflow),  64'(vecs[i].exp_ovf));
        end
        wr_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic wait_step(input int max, output int cyc, output logic seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max) begin
            tick();
            cyc++;
            if (frame_step === 1'b1)
                seen = 1'b1;
        end
    endtask

    task automatic write_col(input logic [4:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [34:0] LOAD7 = 35'h3_0509_1121;

    initial begin
        int   cyc;
        int   pulses;
        logic seen;

        // load 01,02,04,08,10,1F,00 while paused
        vecs[0]  = mk(1, 5'h01, 0, 1, 4'd1, 0, 0);
        vecs[1]  = mk(1, 5'h02, 0, 1, 4'd2, 0, 0);
        vecs[2]  = mk(1, 5'h04, 0, 1, 4'd3, 0, 0);
        vecs[3]  = mk(1, 5'h08, 0, 1, 4'd4, 0, 0);
        vecs[4]  = mk(1, 5'h10, 0, 1, 4'd5, 0, 0);
        vecs[5]  = mk(1, 5'h1F, 0, 1, 4'd6, 0, 0);
        vecs[6]  = mk(1, 5'h00, 0, 1, 4'd7, 0, 0);
        // clear, then short message 1F,00,00
        vecs[7]  = mk(0, 5'h00, 1, 1, 4'd0, 0, 0);
        vecs[8]  = mk(1, 5'h1F, 0, 1, 4'd1, 0, 0);
        vecs[9]  = mk(1, 5'h00, 0, 1, 4'd2, 0, 0);
        vecs[10] = mk(1, 5'h00, 0, 1, 4'd3, 0, 0);
        // clear, then nine writes into an 8-deep buffer
        vecs[11] = mk(0, 5'h00, 1, 1, 4'd0, 0, 0);
        vecs[12] = mk(1, 5'h03, 0, 1, 4'd1, 0, 0);
        vecs[13] = mk(1, 5'h05, 0, 1, 4'd2, 0, 0);
        vecs[14] = mk(1, 5'h06, 0, 1, 4'd3, 0, 0);
        vecs[15] = mk(1, 5'h09, 0, 1, 4'd4, 0, 0);
        vecs[16] = mk(1, 5'h0A, 0, 1, 4'd5, 0, 0);
        vecs[17] = mk(1, 5'h0C, 0, 1, 4'd6, 0, 0);
        vecs[18] = mk(1, 5'h11, 0, 1, 4'd7, 0, 0);
        vecs[19] = mk(1, 5'h12, 0, 1, 4'd8, 1, 0);
        vecs[20] = mk(1, 5'h1F, 0, 1, 4'd8, 1, 1);
        vecs[21] = mk(0, 5'h00, 0, 1, 4'd8, 1, 1);
        // clr and wr_en together: clear wins
        vecs[22] = mk(1, 5'h1F, 1, 1, 4'd0, 0, 0);
        vecs[23] = mk(0, 5'h00, 0, 1, 4'd0, 0, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ens",        64'(ens),        64'd0);
        chk("rst_col_count",  64'(col_count),  64'd0);
        chk("rst_full",       64'(full),       64'd0);
        chk("rst_overflow",   64'(overflow),   64'd0);
        chk("rst_frame_step", 64'(frame_step), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ens",   64'(ens),        64'd0);

        // seven-column load
        run_vectors(0, 6);
        tick();
        chk("load7_ens",        64'(ens),        64'(LOAD7));
        chk("load7_frame_step", 64'(frame_step), 64'd0);

        // scroll left, one column per 4 cycles
        pause = 1'b0;
        wait_step(20, cyc, seen);
        chk("step1_seen",       64'(seen),   64'd1);
        chk("step1_ens",        64'(ens),    64'(frame_of(5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h00, 5'h01)));
        chk("step1_col0_bit7",  64'(ens[7]), 64'd1);
        chk("step1_col6_bit6",  64'(ens[6]), 64'd1);
        tick();
        chk("step1_pulse_width", 64'(frame_step), 64'd0);
        for (int s = 2; s <= 7; s++) begin
            wait_step(20, cyc, seen);
            chk($sformatf("step%0d_seen", s),   64'(seen), 64'd1);
            chk($sformatf("step%0d_period", s), 64'(cyc),  (s == 2) ? 64'd3 : 64'd4);
        end
        chk("step7_ens_wrapped", 64'(ens), 64'(LOAD7));

        // pause freezes the window; resume continues the prescaler count
        pause  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (frame_step === 1'b1) pulses++;
        end
        chk("hold_no_steps", 64'(pulses), 64'd0);
        chk("hold_ens",      64'(ens),    64'(LOAD7));
        pause = 1'b0;
        wait_step(20, cyc, seen);
        chk("resume_seen",    64'(seen), 64'd1);
        chk("resume_latency", 64'(cyc),  64'd4);
        chk("resume_ens",     64'(ens),  64'(frame_of(5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h00, 5'h01)));

        // short message repeats across the window
        run_vectors(7, 7);
        tick();
        chk("clr_ens_zero", 64'(ens), 64'd0);
        run_vectors(8, 10);
        tick();
        chk("short_ens", 64'(ens), 64'(frame_of(5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h1F)));
        pause = 1'b0;
        wait_step(20, cyc, seen);
        chk("short_step_seen", 64'(seen), 64'd1);
        chk("short_step_ens",  64'(ens),  64'(frame_of(5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00)));

        // overflow, then clear together with a write
        run_vectors(11, 21);
        chk("ovf_ens", 64'(ens), 64'(frame_of(5'h03, 5'h05, 5'h06, 5'h09, 5'h0A, 5'h0C, 5'h11)));
        run_vectors(22, 23);
        chk("clr_wr_ens",        64'(ens),        64'd0);
        chk("clr_wr_frame_step", 64'(frame_step), 64'd0);

`ifdef SCROLL_DIR_EN
        // right scroll: start steps back from 0 to len-1
        pause = 1'b1;
        write_col(5'h01); write_col(5'h02); write_col(5'h04); write_col(5'h08);
        write_col(5'h10); write_col(5'h1F); write_col(5'h00);
        dir   = 1'b1;
        pause = 1'b0;
        wait_step(20, cyc, seen);
        chk("dir_step_seen", 64'(seen),   64'd1);
        chk("dir_ens",       64'(ens),    64'(frame_of(5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F)));
        chk("dir_col0_zero", 64'(ens[0]), 64'd0);
        chk("dir_col1_bit1", 64'(ens[1]), 64'd1);
        dir   = 1'b0;
        pause = 1'b1;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        tick();
`endif

        // asynchronous reset mid-scroll
        pause = 1'b0;
        write_col(5'h15); write_col(5'h0A); write_col(5'h1F);
        wait_step(20, cyc, seen);
        chk("mid_seen", 64'(seen), 64'd1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ens",        64'(ens),        64'd0);
        chk("mid_rst_col_count",  64'(col_count),  64'd0);
        chk("mid_rst_full",       64'(full),       64'd0);
        chk("mid_rst_overflow",   64'(overflow),   64'd0);
        chk("mid_rst_frame_step", 64'(frame_step), 64'd0);
        #2;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (frame_step === 1'b1) pulses++;
        end
        chk("post_mid_rst_no_steps", 64'(pulses),    64'd0);
        chk("post_mid_rst_ens",      64'(ens),       64'd0);
        chk("post_mid_rst_count",    64'(col_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
